// File: rtl/pwm_if.sv
// Register-block side bundle for the PWM core: settings flow in, waveform
// and status flow back out.
interface pwm_if #(
  parameter int CNT_W = 16
);
  logic             enable;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] duty_cycle;
  logic [CNT_W-1:0] prescaler;
  logic             pwm_out;
  logic             pwm_running;
  logic             period_done;

  // Register block drives settings and reads status.
  modport master (
    output enable, period, duty_cycle, prescaler,
    input  pwm_out, pwm_running, period_done
  );

  // PWM core consumes settings and drives the pin and status.
  modport slave (
    input  enable, period, duty_cycle, prescaler,
    output pwm_out, pwm_running, period_done
  );
endinterface

// File: rtl/pwm_core.sv
// PWM waveform generator. Settings are shadowed and only take effect at a
// period boundary, so a register write never produces a runt pulse.
// pwm_out is derived from next-state values, so it lines up with the
// counter without an extra cycle of latency.
module pwm_core #(
  parameter int CNT_W       = 16,
  parameter bit ACTIVE_HIGH = 1'b1
) (
  input logic  clk,
  input logic  reset,
  pwm_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  localparam logic INACTIVE = logic'(!ACTIVE_HIGH);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] pre_cnt, pre_cnt_n;
  logic [CNT_W-1:0] per_sh, per_sh_n;
  logic [CNT_W-1:0] duty_sh, duty_sh_n;
  logic [CNT_W-1:0] pre_sh, pre_sh_n;
  logic             pwm_q, pwm_n;
  logic             running_q, running_n;
  logic             done_q, done_n;
  logic             tick;
  logic             period_end;
  logic             load;
  logic             active;

  // Next-state logic: FSM, prescaler/period counters, shadow reloads, outputs.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned; a missing default here would infer a latch.
    state_n    = state;
    cnt_n      = cnt;
    pre_cnt_n  = pre_cnt;
    per_sh_n   = per_sh;
    duty_sh_n  = duty_sh;
    pre_sh_n   = pre_sh;
    done_n     = 1'b0;
    tick       = 1'b0;
    period_end = 1'b0;
    load       = 1'b0;

    case (state)
      IDLE: begin
        if (bus.enable) begin
          state_n   = RUN;
          load      = 1'b1;
          cnt_n     = '0;
          pre_cnt_n = '0;
        end
      end

      RUN, STOPPING: begin
        tick = (pre_cnt == pre_sh);
        if (tick) begin
          pre_cnt_n = '0;
          if (cnt == per_sh) begin
            period_end = 1'b1;
            cnt_n      = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end else begin
          pre_cnt_n = pre_cnt + 1'b1;
        end

        load   = period_end;
        done_n = period_end;

        // A re-assert while stopping resumes without a restart; a stop only
        // completes at a period boundary.
        if (bus.enable) begin
          state_n = RUN;
        end else if (period_end) begin
          state_n   = IDLE;
          cnt_n     = '0;
          pre_cnt_n = '0;
        end else begin
          state_n = STOPPING;
        end
      end

      default: state_n = IDLE;
    endcase

    if (load) begin
      per_sh_n  = bus.period;
      duty_sh_n = bus.duty_cycle;
      pre_sh_n  = bus.prescaler;
    end

    running_n = (state_n != IDLE);
    active    = running_n && (cnt_n < duty_sh_n);
    pwm_n     = active ? ~INACTIVE : INACTIVE;
  end

  // State, counters, shadows and registered outputs.
  // NOTE: reset is asynchronous so the pin drops to its inactive level at
  // once, without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      pre_cnt   <= '0;
      per_sh    <= '0;
      duty_sh   <= '0;
      pre_sh    <= '0;
      pwm_q     <= INACTIVE;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state     <= state_n;
      cnt       <= cnt_n;
      pre_cnt   <= pre_cnt_n;
      per_sh    <= per_sh_n;
      duty_sh   <= duty_sh_n;
      pre_sh    <= pre_sh_n;
      pwm_q     <= pwm_n;
      running_q <= running_n;
      done_q    <= done_n;
    end
  end

  assign bus.pwm_out     = pwm_q;
  assign bus.pwm_running = running_q;
  assign bus.period_done = done_q;

endmodule

// File: tb/tb_pwm_core.sv
// Scoreboard bench for pwm_core. Two instances share the same settings: one
// active-high, one active-low. Each test pushes the per-clock waveform it
// expects, then samples both instances on the falling edge and pops.
module tb_pwm_core;

  localparam int CNT_W = 16;

  typedef struct packed {
    logic pwm;
    logic done;
    logic run;
  } obs_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] duty_cycle;
  logic [CNT_W-1:0] prescaler;

  obs_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  pwm_if #(.CNT_W(CNT_W)) bus_hi ();
  pwm_if #(.CNT_W(CNT_W)) bus_lo ();

  assign bus_hi.enable     = enable;
  assign bus_hi.period     = period;
  assign bus_hi.duty_cycle = duty_cycle;
  assign bus_hi.prescaler  = prescaler;
  assign bus_lo.enable     = enable;
  assign bus_lo.period     = period;
  assign bus_lo.duty_cycle = duty_cycle;
  assign bus_lo.prescaler  = prescaler;

  pwm_core #(.CNT_W(CNT_W), .ACTIVE_HIGH(1'b1)) dut_hi (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_hi.slave)
  );

  pwm_core #(.CNT_W(CNT_W), .ACTIVE_HIGH(1'b0)) dut_lo (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_lo.slave)
  );

  // Expected waveform of n_per periods; j is the clk index within a period.
  // The first period after start has no period_done at j=0.
  task automatic push_run(input int per, input int pre, input int duty,
                          input int n_per, input bit first);
    obs_t e;
    for (int p = 0; p < n_per; p++) begin
      for (int j = 0; j < (per + 1) * (pre + 1); j++) begin
        e.pwm  = ((j / (pre + 1)) < duty);
        e.done = (j == 0) && !(first && (p == 0));
        e.run  = 1'b1;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(obs_t'(3'b000));
  endtask

  // Final period_done as the block drops to idle, then quiet idle cycles.
  task automatic push_stop(input int n_idle);
    exp_q.push_back(obs_t'(3'b010));
    push_idle(n_idle);
  endtask

  // Pop one expectation and compare it to both instances (low one inverted).
  task automatic compare(input string name, input int idx);
    obs_t e, a, b;
    if (exp_q.size() == 0) begin
      checks++;
      $display("FAIL %s[%0d]: scoreboard empty, expected entry required", name, idx);
      return;
    end
    e = exp_q.pop_front();
    a = {bus_hi.pwm_out, bus_hi.period_done, bus_hi.pwm_running};
    b = {~bus_lo.pwm_out, bus_lo.period_done, bus_lo.pwm_running};
    checks++;
    if (a !== e)
      $display("FAIL %s[%0d] active_high pwm/done/run: got %b required %b", name, idx, a, e);
    else
      passed++;
    checks++;
    if (b !== e)
      $display("FAIL %s[%0d] active_low ~pwm/done/run: got %b required %b", name, idx, b, e);
    else
      passed++;
  endtask

  task automatic run_check(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      compare(name, i);
    end
  endtask

  task automatic setup(input int per, input int pre, input int duty);
    period     = CNT_W'(per);
    prescaler  = CNT_W'(pre);
    duty_cycle = CNT_W'(duty);
  endtask

  task automatic test_reset;
    exp_q.push_back(obs_t'(3'b000));
    compare("reset_state", 0);
    @(negedge clk);
    reset = 1'b0;
    push_idle(2);
    run_check(2, "idle_after_reset");
  endtask

  task automatic test_basic;
    setup(9, 0, 3);
    enable = 1'b1;
    push_run(9, 0, 3, 3, 1'b1);
    run_check(30, "basic");
    enable = 1'b0;
    push_stop(2);
    run_check(3, "basic_stop");
  endtask

  task automatic test_prescaler;
    setup(9, 1, 3);
    enable = 1'b1;
    push_run(9, 1, 3, 1, 1'b1);
    push_run(9, 0, 3, 2, 1'b0);
    run_check(8, "presc_a");
    prescaler = '0;
    run_check(32, "presc_b");
    enable = 1'b0;
    push_stop(2);
    run_check(3, "presc_stop");
  endtask

  task automatic test_duty_extremes;
    setup(9, 0, 0);
    enable = 1'b1;
    push_run(9, 0, 0, 2, 1'b1);
    run_check(20, "duty_zero");
    enable = 1'b0;
    push_stop(1);
    run_check(2, "duty_zero_stop");

    setup(9, 0, 12);
    enable = 1'b1;
    push_run(9, 0, 12, 2, 1'b1);
    run_check(20, "duty_full");
    enable = 1'b0;
    push_stop(1);
    run_check(2, "duty_full_stop");

    setup(0, 0, 1);
    enable = 1'b1;
    push_run(0, 0, 1, 8, 1'b1);
    run_check(8, "one_tick");
    enable = 1'b0;
    push_stop(1);
    run_check(2, "one_tick_stop");
  endtask

  task automatic test_midperiod_duty;
    setup(9, 0, 3);
    enable = 1'b1;
    push_run(9, 0, 3, 1, 1'b1);
    push_run(9, 0, 7, 1, 1'b0);
    run_check(6, "duty_chg_a");
    duty_cycle = CNT_W'(7);
    run_check(14, "duty_chg_b");
    enable = 1'b0;
    push_stop(1);
    run_check(2, "duty_chg_stop");
  endtask

  task automatic test_stop;
    setup(9, 0, 3);
    enable = 1'b1;
    push_run(9, 0, 3, 2, 1'b1);
    push_stop(2);
    run_check(15, "stop_a");
    enable = 1'b0;
    run_check(8, "stop_b");
  endtask

  task automatic test_stop_resume;
    setup(9, 0, 3);
    enable = 1'b1;
    push_run(9, 0, 3, 3, 1'b1);
    run_check(15, "resume_a");
    enable = 1'b0;
    run_check(3, "resume_b");
    enable = 1'b1;
    run_check(12, "resume_c");
    enable = 1'b0;
    push_stop(1);
    run_check(2, "resume_stop");
  endtask

  task automatic test_async_reset;
    setup(9, 0, 3);
    enable = 1'b1;
    push_run(9, 0, 3, 1, 1'b1);
    run_check(2, "areset_run");
    exp_q.delete();
    #2;
    reset = 1'b1;
    #1;
    exp_q.push_back(obs_t'(3'b000));
    compare("areset_immediate", 0);
    @(negedge clk);
    exp_q.push_back(obs_t'(3'b000));
    compare("areset_held", 0);
    reset = 1'b0;
    push_run(9, 0, 3, 2, 1'b1);
    run_check(20, "areset_restart");
    enable = 1'b0;
    push_stop(1);
    run_check(2, "areset_stop");
  endtask

  initial begin
    reset  = 1'b0;
    enable = 1'b0;
    setup(0, 0, 0);
    #1;
    reset = 1'b1;
    #1;
    test_reset();
    test_basic();
    test_prescaler();
    test_duty_extremes();
    test_midperiod_duty();
    test_stop();
    test_stop_resume();
    test_async_reset();
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL scoreboard_drain: got %0d leftover entries required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pwm_core.md
Name: pwm_core

Overview:
- PWM waveform generator that sits directly downstream of the PWM control/status register block.
- Consumes the block's enable, period, duty_cycle and prescaler outputs.
- Produces the PWM output pin and the pwm_running status bit that the register block reads back.
- Setting changes are double-buffered (shadowed) and applied only at period boundaries, so the output never glitches.

Parameters:
- CNT_W, 16: width of the period, duty and prescaler counters and inputs.
- ACTIVE_HIGH, 1: 1 = pwm_out is high during the duty phase; 0 = output is inverted. The idle level is always the inactive level.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  run request (level).
- period  input  CNT_W  period length minus 1, in prescaled ticks.
- duty_cycle  input  CNT_W  number of active ticks per period.
- prescaler  input  CNT_W  tick divisor minus 1; 0 gives one tick every clk.
- pwm_out  output  1  PWM waveform, registered.
- pwm_running  output  1  high while state is not IDLE, registered.
- period_done  output  1  one-clk pulse at the end of each completed period.

Behaviour:
- Clock and reset: reset reset, asynchronous, active-high; clock clk. On reset, all outputs go inactive immediately and the block enters IDLE:
  - pwm_out = inactive level, pwm_running = 0, period_done = 0.
  - cnt = 0, pre_cnt = 0, all shadow registers = 0, state = IDLE.
- Internal registers:
  - state: IDLE / RUN / STOPPING.
  - pre_cnt: prescaler count.
  - cnt: period count.
  - Shadows: per_sh, duty_sh, pre_sh.
- Tick generation:
  - tick = (pre_cnt == pre_sh), evaluated only when state is not IDLE.
  - On tick, pre_cnt returns to 0; otherwise it increments.
- Period counting:
  - On tick, cnt increments. When cnt == per_sh on a tick, cnt wraps to 0; this is the period end.
  - A period lasts (per_sh+1)*(pre_sh+1) clk cycles.
- Shadow loading: per_sh, duty_sh and pre_sh load from the inputs on the IDLE->RUN edge and at every period end. Input changes mid-period have no effect until the next period.
- Output function: in every cycle, pwm_out = active when (state != IDLE && cnt < duty_sh), else inactive. It is computed from next-state values so there is no added latency.
  - duty_sh = 0 gives 0% duty (constant inactive).
  - duty_sh > per_sh gives 100% duty (constant active).
  - per_sh = 0 gives a period of one tick.
- State machine:
  - IDLE -> RUN on the edge where enable = 1. At that edge: shadows load, cnt = 0, pre_cnt = 0, pwm_running = 1. pwm_out reflects cnt = 0 in the following cycle.
  - RUN -> STOPPING on the edge where enable = 0. Counting continues normally.
  - STOPPING -> RUN when enable = 1 again before the period end. There is no restart and the waveform is unbroken.
  - STOPPING -> IDLE at the period end. cnt and pre_cnt clear, pwm_running = 0, and pwm_out goes inactive in the same cycle.
  - Simultaneous period end and enable = 0 in RUN goes directly to IDLE.
- period_done:
  - Registered; high for exactly one clk following each period-end edge in both RUN and STOPPING.
  - Never asserted in IDLE.
  - A one-tick period (per_sh = 0) with pre_sh = 0 keeps period_done high continuously.
- Reset mid-operation: reset aborts immediately, with no graceful stop.

Test Plan:
- prescaler=0, period=9, duty_cycle=3, enable 0->1: pwm_running rises the next clk; pwm_out is high 3 clk then low 7 clk, repeating every 10 clk; period_done pulses once per 10 clk.
- prescaler=1, period=9, duty_cycle=3: period is 20 clk, high phase is 6 clk; a prescaler change to 0 mid-period takes effect only from the next boundary.
- duty_cycle=0 -> pwm_out constant low while running; duty_cycle=12 with period=9 -> constant high; period=0 with duty_cycle=1 -> constant high and period_done high every clk.
- Running with period=9, duty_cycle=3; write duty_cycle=7 at clk 5 of a period: that period still has 3 high clk, and the next period has 7 high clk.
- Drop enable at clk 4 of a period: the waveform completes through clk 9, then pwm_running=0 and pwm_out=0 with one final period_done. Repeat, but re-assert enable at clk 7: no gap, and pwm_running stays 1.
- Assert reset during the high phase: pwm_out, pwm_running and period_done go to 0 without waiting for a clk edge. After release with enable=1, the first period begins at cnt=0.
- With ACTIVE_HIGH=0, repeat the first test: pwm_out is the exact inverse of the first test while running, and high when idle.
